// File: rtl/atconv_pkg.sv
// ----------------------------------------------------------------------------
// atconv_pkg
// Shared constants and types for the accelerator host-side memory block.
//   DW / IMG_AW / L1_AW       : data width and address widths
//   IMG_DEPTH / L1_DEPTH      : entries in image/layer-0 and layer-1 memories
//   TIMEOUT_DEF / TO_W        : default KICK+RUN watchdog limit and counter width
//   state_t                   : job sequencer states
//   l1_out_of_range()         : true when a 12-bit layer address misses layer-1
// ----------------------------------------------------------------------------
package atconv_pkg;

    localparam int DW          = 13;
    localparam int IMG_AW      = 12;
    localparam int L1_AW       = 10;
    localparam int IMG_DEPTH   = 4096;
    localparam int L1_DEPTH    = 1024;
    localparam int TIMEOUT_DEF = 200000;
    localparam int TO_W        = 18;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        KICK = 3'd2,
        RUN  = 3'd3,
        DUMP = 3'd4,
        DONE = 3'd5
    } state_t;

    // Layer-1 only decodes the low L1_AW bits; any set upper bit is a miss.
    function automatic logic l1_out_of_range(input logic [IMG_AW-1:0] addr);
        return (addr[IMG_AW-1:L1_AW] != 2'b00);
    endfunction

endpackage

// File: rtl/atconv_sram.sv
// ----------------------------------------------------------------------------
// atconv_sram
// Simple memory: one synchronous write port, one asynchronous read port,
// no reset (contents survive reset). Read-during-write returns the old word.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : mem[raddr], combinational
// ----------------------------------------------------------------------------
module atconv_sram #(
    parameter int DEPTH = 1024,
    parameter int W     = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port: updates land on the clock edge, so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/atconv_host_mem.sv
// ----------------------------------------------------------------------------
// atconv_host_mem
// Host side of the dilated-conv / max-pool accelerator. Owns the image memory,
// the layer-0 and layer-1 buffers, and sequences one job:
//   IDLE -> LOAD (4096 image beats) -> KICK (ready) -> RUN (busy high)
//        -> DUMP (1024 layer-1 beats out) -> DONE (done pulse) -> IDLE
// A watchdog covering KICK+RUN aborts the job with err and a done pulse.
// Ports:
//   clk, reset (async, active low)
//   start                          : job request, honoured in IDLE only
//   load_valid/load_data/load_ready: image load stream
//   ready / busy                   : handshake with the accelerator
//   iaddr / idata                  : image read, combinational
//   cwr/caddr_wr/cdata_wr          : layer write port (RUN only)
//   crd/caddr_rd/cdata_rd          : layer read port, combinational
//   csel                           : 0 = layer-0, 1 = layer-1
//   out_valid/out_data/out_addr/out_ready : layer-1 result stream
//   done, err, addr_err            : status
// ----------------------------------------------------------------------------
module atconv_host_mem
    import atconv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_valid,
    input  logic [DW-1:0]     load_data,
    output logic              load_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    input  logic              csel,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [L1_AW-1:0]  out_addr,
    input  logic              out_ready,
    output logic              done,
    output logic              err,
    output logic              addr_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state_r;
    logic [IMG_AW-1:0] load_cnt_r;
    logic [L1_AW-1:0]  dump_cnt_r;
    logic [TO_W-1:0]   tcnt_r;

    logic              load_fire_s;
    logic              out_fire_s;
    logic              l0_we_s;
    logic              l1_we_s;
    logic              addr_viol_s;
    logic [L1_AW-1:0]  l1_raddr_s;
    logic [DW-1:0]     l0_rdata_s;
    logic [DW-1:0]     l1_rdata_s;

    assign load_fire_s = load_valid && load_ready;
    assign out_fire_s  = out_valid && out_ready;
    assign l0_we_s     = (state_r == RUN) && cwr && !csel;
    assign l1_we_s     = (state_r == RUN) && cwr && csel && !l1_out_of_range(caddr_wr);
    assign addr_viol_s = (crd && csel && l1_out_of_range(caddr_rd)) ||
                         ((state_r == RUN) && cwr && csel && l1_out_of_range(caddr_wr));
    assign out_addr    = dump_cnt_r;

    atconv_sram #(.DEPTH(IMG_DEPTH), .W(DW)) u_image (
        .clk   (clk),
        .we    (load_fire_s),
        .waddr (load_cnt_r),
        .wdata (load_data),
        .raddr (iaddr),
        .rdata (idata)
    );

    atconv_sram #(.DEPTH(IMG_DEPTH), .W(DW)) u_l0 (
        .clk   (clk),
        .we    (l0_we_s),
        .waddr (caddr_wr),
        .wdata (cdata_wr),
        .raddr (caddr_rd),
        .rdata (l0_rdata_s)
    );

    atconv_sram #(.DEPTH(L1_DEPTH), .W(DW)) u_l1 (
        .clk   (clk),
        .we    (l1_we_s),
        .waddr (caddr_wr[L1_AW-1:0]),
        .wdata (cdata_wr),
        .raddr (l1_raddr_s),
        .rdata (l1_rdata_s)
    );

    // Layer-1 read address: the result stream borrows the port once the
    // accelerator has dropped busy, prefetching the word for the next beat.
    always_comb begin
        l1_raddr_s = caddr_rd[L1_AW-1:0];
        if (state_r == DUMP) begin
            if (out_fire_s) begin
                l1_raddr_s = dump_cnt_r + 10'd1;
            end else begin
                l1_raddr_s = dump_cnt_r;
            end
        end else if ((state_r == RUN) && !busy) begin
            l1_raddr_s = 10'd0;
        end else begin
            l1_raddr_s = caddr_rd[L1_AW-1:0];
        end
    end

    // Layer read mux: zero when not strobed or when layer-1 is missed.
    always_comb begin
        cdata_rd = {DW{1'b0}};
        if (crd) begin
            if (!csel) begin
                cdata_rd = l0_rdata_s;
            end else if (!l1_out_of_range(caddr_rd)) begin
                cdata_rd = l1_rdata_s;
            end else begin
                cdata_rd = {DW{1'b0}};
            end
        end else begin
            cdata_rd = {DW{1'b0}};
        end
    end

    // Job sequencer with all status and stream outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            load_cnt_r <= 12'd0;
            dump_cnt_r <= 10'd0;
            tcnt_r     <= 18'd0;
            load_ready <= 1'b0;
            ready      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 13'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Sticky address error; a new job clears it.
            if ((state_r == IDLE) && start) begin
                addr_err <= 1'b0;
            end else if (addr_viol_s) begin
                addr_err <= 1'b1;
            end else begin
                addr_err <= addr_err;
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= LOAD;
                        load_ready <= 1'b1;
                        load_cnt_r <= 12'd0;
                        err        <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_fire_s) begin
                        load_cnt_r <= load_cnt_r + 12'd1;
                        if (load_cnt_r == 12'd4095) begin
                            state_r    <= KICK;
                            load_ready <= 1'b0;
                            ready      <= 1'b1;
                            tcnt_r     <= 18'd0;
                        end
                    end
                end
                KICK: begin
                    if (tcnt_r == TO_LAST) begin
                        state_r <= IDLE;
                        ready   <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                    end else begin
                        tcnt_r <= tcnt_r + 18'd1;
                        if (busy) begin
                            state_r <= RUN;
                            ready   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // busy was seen high in KICK, so a low sample here is its falling edge.
                    if (tcnt_r == TO_LAST) begin
                        state_r <= IDLE;
                        err     <= 1'b1;
                        done    <= 1'b1;
                    end else if (!busy) begin
                        state_r    <= DUMP;
                        dump_cnt_r <= 10'd0;
                        out_valid  <= 1'b1;
                        out_data   <= l1_rdata_s;
                    end else begin
                        tcnt_r <= tcnt_r + 18'd1;
                    end
                end
                DUMP: begin
                    if (out_fire_s) begin
                        if (dump_cnt_r == 10'd1023) begin
                            state_r   <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            dump_cnt_r <= dump_cnt_r + 10'd1;
                            out_data   <= l1_rdata_s;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r    <= IDLE;
                    load_ready <= 1'b0;
                    ready      <= 1'b0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atconv_host_mem.sv
// ----------------------------------------------------------------------------
// tb_atconv_host_mem
// Directed bench for atconv_host_mem. Instance u_dut runs a full job with a
// simple accelerator model; instance u_to shares the load stream but never
// sees busy, so it exercises the KICK watchdog with TIMEOUT=50.
// ----------------------------------------------------------------------------
module tb_atconv_host_mem;

    typedef struct {
        logic        csel;
        logic        cwr;
        logic [11:0] wa;
        logic [12:0] wd;
        logic        crd;
        logic [11:0] ra;
        logic [12:0] exp_rd;
        logic        exp_ae;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        load_valid = 1'b0;
    logic [12:0] load_data = 13'd0;
    logic        busy = 1'b0;
    logic [11:0] iaddr = 12'd0;
    logic        cwr = 1'b0;
    logic [11:0] caddr_wr = 12'd0;
    logic [12:0] cdata_wr = 13'd0;
    logic        crd = 1'b0;
    logic [11:0] caddr_rd = 12'd0;
    logic        csel = 1'b0;
    logic        out_ready = 1'b0;

    logic        load_ready, ready, out_valid, done, err, addr_err;
    logic [12:0] idata, cdata_rd, out_data;
    logic [9:0]  out_addr;

    logic        load_ready2, ready2, out_valid2, done2, err2, addr_err2;
    logic [12:0] idata2, cdata_rd2, out_data2;
    logic [9:0]  out_addr2;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[10];

    always #5 clk = ~clk;

    atconv_host_mem u_dut (
        .clk(clk), .reset(rst_n), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
        .out_ready(out_ready), .done(done), .err(err), .addr_err(addr_err)
    );

    atconv_host_mem #(.TIMEOUT(50)) u_to (
        .clk(clk), .reset(rst_n), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready2),
        .ready(ready2), .busy(1'b0), .iaddr(iaddr), .idata(idata2),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd2), .csel(csel),
        .out_valid(out_valid2), .out_data(out_data2), .out_addr(out_addr2),
        .out_ready(out_ready), .done(done2), .err(err2), .addr_err(addr_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [12:0] l1_val(input int n);
        return 13'(n * 16);
    endfunction

    initial begin
        int k;
        int cyc;
        int idx;
        logic acc;
        logic [3:0] pat;

        //           csel  cwr   wa        wd         crd   ra        exp_rd     exp_ae
        vecs[0] = '{1'b0, 1'b1, 12'd5,    13'd7,     1'b0, 12'd0,    13'd0,     1'b0};
        vecs[1] = '{1'b0, 1'b1, 12'd5,    13'd9,     1'b1, 12'd5,    13'd7,     1'b0};
        vecs[2] = '{1'b0, 1'b0, 12'd0,    13'd0,     1'b1, 12'd5,    13'd9,     1'b0};
        vecs[3] = '{1'b1, 1'b0, 12'd0,    13'd0,     1'b1, 12'd976,  13'd7424,  1'b0};
        vecs[4] = '{1'b1, 1'b1, 12'd2000, 13'd1234,  1'b1, 12'd976,  13'd7424,  1'b1};
        vecs[5] = '{1'b1, 1'b0, 12'd0,    13'd0,     1'b1, 12'd976,  13'd7424,  1'b1};
        vecs[6] = '{1'b0, 1'b1, 12'd4095, 13'h1abc,  1'b0, 12'd0,    13'd0,     1'b1};
        vecs[7] = '{1'b0, 1'b0, 12'd0,    13'd0,     1'b1, 12'd4095, 13'h1abc,  1'b1};
        vecs[8] = '{1'b1, 1'b0, 12'd0,    13'd0,     1'b1, 12'd1023, 13'd8176,  1'b1};
        vecs[9] = '{1'b1, 1'b0, 12'd0,    13'd0,     1'b1, 12'd1024, 13'd0,     1'b1};

        // Reset values
        #12;
        chk("rst_ready", ready, 1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a load, after 100 beats
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_ready_rise", load_ready, 1'b1);
        for (int i = 0; i < 100; i++) begin
            load_valid = 1'b1;
            load_data  = 13'(i);
            tick();
        end
        load_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_load_ready", load_ready, 1'b0);
        chk("midrst_ready", ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", load_ready, 1'b0);

        // Full image load with gaps, image[k] = k
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 4096 && cyc < 10000) begin
            load_valid = (cyc % 9 != 4);
            load_data  = 13'(k);
            acc = load_valid && load_ready;
            if (k == 4095) begin
                chk("ready_early", ready, 1'b0);
            end
            tick();
            if (acc) k++;
            cyc++;
        end
        load_valid = 1'b0;
        chk("load_beats", k, 4096);
        chk("load_ready_drop", load_ready, 1'b0);
        chk("ready_rise", ready, 1'b1);
        chk("ready2_rise", ready2, 1'b1);
        iaddr = 12'd37;
        #1;
        chk("idata_37", idata, 13'd37);
        chk("idata2_37", idata2, 13'd37);
        iaddr = 12'd4095;
        #1;
        chk("idata_4095", idata, 13'd4095);

        // Both in KICK; u_dut sees no busy yet, u_to must time out after 50 cycles
        for (int i = 1; i <= 51; i++) begin
            tick();
            if (i == 49) begin
                chk("to_err_early", err2, 1'b0);
                chk("to_ready_held", ready2, 1'b1);
            end
            if (i == 50) begin
                chk("to_err", err2, 1'b1);
                chk("to_done", done2, 1'b1);
                chk("to_ready_low", ready2, 1'b0);
            end
            if (i == 51) begin
                chk("to_done_pulse", done2, 1'b0);
                chk("to_err_held", err2, 1'b1);
            end
        end
        chk("ready_held", ready, 1'b1);
        chk("no_early_done", done, 1'b0);

        // Accelerator raises busy; ready falls on the next cycle
        busy = 1'b1;
        tick();
        chk("ready_fall", ready, 1'b0);

        // Accelerator fills layer-1 with n*16
        for (int n = 0; n < 1024; n++) begin
            cwr      = 1'b1;
            csel     = 1'b1;
            caddr_wr = 12'(n);
            cdata_wr = l1_val(n);
            tick();
        end
        cwr = 1'b0;

        // Layer port vectors while RUN
        for (int i = 0; i < 10; i++) begin
            csel     = vecs[i].csel;
            cwr      = vecs[i].cwr;
            caddr_wr = vecs[i].wa;
            cdata_wr = vecs[i].wd;
            crd      = vecs[i].crd;
            caddr_rd = vecs[i].ra;
            #1;
            chk($sformatf("vec%0d_rd", i), cdata_rd, vecs[i].exp_rd);
            tick();
            chk($sformatf("vec%0d_addr_err", i), addr_err, vecs[i].exp_ae);
        end
        cwr  = 1'b0;
        crd  = 1'b0;
        csel = 1'b0;
        #1;
        chk("rd_idle_zero", cdata_rd, 13'd0);

        // busy falls -> dump with backpressure pattern 1,0,0,1
        busy = 1'b0;
        tick();
        pat = 4'b1001;
        idx = 0;
        cyc = 0;
        while (idx < 1024 && cyc < 8000) begin
            out_ready = pat[cyc % 4];
            chk("dump_valid", out_valid, 1'b1);
            chk("dump_addr", out_addr, idx);
            chk("dump_data", out_data, l1_val(idx));
            chk("dump_no_done", done, 1'b0);
            tick();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("dump_beats", idx, 1024);
        chk("dump_valid_drop", out_valid, 1'b0);
        chk("done_pulse", done, 1'b1);
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("err_clean", err, 1'b0);

        // Layer write outside RUN is ignored
        csel     = 1'b0;
        cwr      = 1'b1;
        caddr_wr = 12'd5;
        cdata_wr = 13'd3;
        tick();
        cwr      = 1'b0;
        crd      = 1'b1;
        caddr_rd = 12'd5;
        #1;
        chk("idle_write_ignored", cdata_rd, 13'd9);
        crd = 1'b0;
        #1;
        chk("to_cdata_rd_zero", cdata_rd2, 13'd0);
        chk("to_out_valid", out_valid2, 1'b0);
        chk("to_out_addr", out_addr2, 10'd0);
        chk("to_out_data", out_data2, 13'd0);
        chk("to_load_ready", load_ready2, 1'b0);
        chk("addr_err_sticky", addr_err, 1'b1);
        chk("to_addr_err_read", addr_err2, 1'b1);

        // Next start clears addr_err and err
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clr_addr_err", addr_err, 1'b0);
        chk("start_clr_addr_err2", addr_err2, 1'b0);
        chk("start_clr_err2", err2, 1'b0);
        chk("restart_load_ready", load_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
